btn_debouncer: RTL and testbench
================================

Name: btn_debouncer

Overview:
- Upstream stage of the button interpreter.
- Takes the four raw, asynchronous, bouncing board push-buttons and synchronises each one to clk.
- Debounces each button independently and drives clean levels, which feed the interpreter's btns input directly.
- Also emits a one-cycle press pulse per button for edge-triggered consumers (menu/start logic).

Parameters:
- N_BTNS, 4, number of buttons handled.
- DEBOUNCE_CYCLES, 1000000, consecutive mismatching samples needed to accept a new level (10 ms at 100 MHz). Legal range ≥ 2. Bench uses 8.
- CNT_W, $clog2(DEBOUNCE_CYCLES), counter width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- btns_raw  input  N_BTNS  raw button pins, asynchronous to clk.
- btns  output  N_BTNS  debounced level per button; bit i = button i held.
- btns_rise  output  N_BTNS  one-cycle pulse when btns[i] goes 0->1.
- stable  output  1  high when every button's synchronised input equals its debounced level (no pending change).

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high. While rst=1, all flops clear: sync stages, counters, btns, btns_rise and stable.
- Reset values: btns=0, btns_rise=0, stable=1 after the first edge with sync stages at 0. stable reads 1 combinationally during reset, because sync=0 equals state=0.
- Synchroniser: 2-FF per bit, sync1 <= btns_raw and sync2 <= sync1. No logic between the two stages.
- Per-button channel, evaluated each rising edge:
  - sync2 == state: counter <= 0.
  - sync2 != state and counter != DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != state and counter == DEBOUNCE_CYCLES-1: state <= ~state, counter <= 0.
  - btns = state.
- Latency:
  - Let E0 be the edge that first captures a new raw value in sync1.
  - If the raw value holds, btns changes on edge E0+DEBOUNCE_CYCLES+1.
  - A raw pulse lasting G cycles changes btns only if G ≥ DEBOUNCE_CYCLES. G ≤ DEBOUNCE_CYCLES-1 is filtered out completely.
- Bounce: any return of sync2 to state clears the counter, so the full count restarts from the last bounce.
- btns_rise:
  - Registered. High for exactly the one cycle in which btns[i] first reads 1.
  - Equivalent to state_next & ~state, captured on the same edge.
  - No pulse on release.
  - A held button never re-pulses.
- Channels are fully independent. Simultaneous changes on several bits flip on the same edge, and their rise pulses coincide. Multi-hot btns is legal; the downstream interpreter treats it as not pressed.
- stable = AND over i of (sync2[i] == state[i]). Purely combinational from flops.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap is possible.
- Reset mid-count: the counter is lost and btns returns to 0. After reset release, a still-held button needs the full DEBOUNCE_CYCLES+1 edges from its first capture to appear again, and generates a rise pulse when it does.

Decomposition:
- Shared package holds:
  - N_BTNS_DEFAULT = 4.
  - DEBOUNCE_CYCLES_SYNTH = 1000000.
  - DEBOUNCE_CYCLES_SIM = 8.
  - Button index constants BTN_UP=0, BTN_RIGHT=1, BTN_DOWN=2, BTN_LEFT=3. These match the interpreter's num mapping.
- One sub-module is natural: btn_debounce_chan. It holds a single-bit synchroniser, counter, state and rise flop, and is instantiated N_BTNS times in a generate loop. stable is reduced at the top level.

Test Plan (DEBOUNCE_CYCLES=8):
1. Reset: assert rst with btns_raw=4'b1111 -> btns=0 and btns_rise=0 during reset. btns=4'b1111 exactly 9 edges after the first post-reset capture edge, with btns_rise=4'b1111 for one cycle.
2. Clean press: btns_raw 0->4'b0100 held -> btns=4'b0100 on E0+9, btns_rise=4'b0100 for one cycle only, stable=0 from E1 to E0+9 then 1.
3. Bounce: raw[0] toggles every 3 cycles for 30 cycles, then holds 1 -> btns[0] stays 0 throughout the bouncing and rises 9 edges after the final capture, with a single rise pulse.
4. Glitch filter:
   - raw[1] high for 7 cycles -> btns unchanged, btns_rise never asserted.
   - raw[1] high for 8 cycles -> btns[1] pulses high for exactly 8 cycles, then drops.
5. Simultaneous: raw 0->4'b1001 in the same cycle -> btns=4'b1001 and btns_rise=4'b1001 on the same edge. Release of bit 3 alone -> btns=4'b0001 after 9 edges, no rise pulse.
6. Async reset mid-count: press raw[2], assert rst asynchronously at count 5 -> btns=0 immediately without waiting for a clock edge. After release, with raw still held, btns[2] rises 9 edges after the first capture.

Source files
------------

// File: rtl/btn_debouncer_pkg.sv
// Shared constants for the push-button debouncer and its consumers.
// Button indices follow the interpreter's num mapping.
package btn_debouncer_pkg;

  localparam int N_BTNS_DEFAULT        = 4;
  localparam int DEBOUNCE_CYCLES_SYNTH = 1000000;
  localparam int DEBOUNCE_CYCLES_SIM   = 8;

  localparam int BTN_UP    = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 3;

endpackage

// File: rtl/btn_debouncer_if.sv
// Button bundle between the board pins and the debouncer: raw pins in,
// clean levels, press pulses and the stable flag out.
interface btn_debouncer_if
  import btn_debouncer_pkg::*;
#(
  parameter int N_BTNS = N_BTNS_DEFAULT
);

  logic [N_BTNS-1:0] btns_raw;
  logic [N_BTNS-1:0] btns;
  logic [N_BTNS-1:0] btns_rise;
  logic              stable;

  modport master (output btns_raw, input btns, btns_rise, stable);
  modport slave  (input btns_raw, output btns, btns_rise, stable);

endinterface

// File: rtl/btn_debounce_chan.sv
// One debounced button: 2-FF synchroniser, mismatch counter, accepted level
// and a registered rising-edge pulse.
module btn_debounce_chan
  import btn_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYNTH
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic btn_o,
  output logic rise_o,
  output logic match_o
);

  localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             state_q, state_d;
  logic             rise_q,  rise_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Any sample agreeing with the accepted level restarts the count, so the
  // full window is measured from the last bounce.
  always_comb begin
    // NOTE: every output gets a default before the branches, so no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      state_d = ~state_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = state_d & ~state_q;
  end

  // NOTE: state is updated with <= only; the comb block above uses = because it has no memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign btn_o   = state_q;
  assign rise_o  = rise_q;
  assign match_o = (sync2_q == state_q);

endmodule

// File: rtl/btn_debouncer.sv
// Debounces N_BTNS asynchronous board buttons into clean levels and press
// pulses; stable reports that no channel has a change pending.
module btn_debouncer
  import btn_debouncer_pkg::*;
#(
  parameter int N_BTNS          = N_BTNS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SYNTH
) (
  input  logic            clk,
  input  logic            rst,
  btn_debouncer_if.slave  bus
);

  logic [N_BTNS-1:0] btn_lvl;
  logic [N_BTNS-1:0] btn_rise;
  logic [N_BTNS-1:0] btn_match;

  for (genvar i = 0; i < N_BTNS; i++) begin : g_chan
    btn_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (bus.btns_raw[i]),
      .btn_o   (btn_lvl[i]),
      .rise_o  (btn_rise[i]),
      .match_o (btn_match[i])
    );
  end

  assign bus.btns      = btn_lvl;
  assign bus.btns_rise = btn_rise;
  assign bus.stable    = &btn_match;

endmodule

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with DEBOUNCE_CYCLES=8: reset, press,
// bounce, glitch filtering, simultaneous buttons and async reset mid-count.
module tb_btn_debouncer;
  import btn_debouncer_pkg::*;

  localparam int NB = N_BTNS_DEFAULT;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  btn_debouncer_if #(.N_BTNS(NB)) bus ();

  btn_debouncer #(
    .N_BTNS          (NB),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_SIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    // 1. Reset with all buttons held
    rst = 1'b1;
    bus.btns_raw = 4'b1111;
    #1;
    check("rst_btns", bus.btns, 4'b0000);
    check("rst_rise", bus.btns_rise, 4'b0000);
    check("rst_stable", {3'b0, bus.stable}, 4'b0001);
    step(2);
    check("rst_btns_clk", bus.btns, 4'b0000);
    check("rst_rise_clk", bus.btns_rise, 4'b0000);
    rst = 1'b0;
    step(9);
    check("rst_pre_e9", bus.btns, 4'b0000);
    step(1);
    check("rst_e9_btns", bus.btns, 4'b1111);
    check("rst_e9_rise", bus.btns_rise, 4'b1111);
    step(1);
    check("rst_e10_rise", bus.btns_rise, 4'b0000);
    check("rst_e10_btns", bus.btns, 4'b1111);

    // Release all: no rise pulse on release
    bus.btns_raw = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("rel_rise", bus.btns_rise, 4'b0000);
    end
    check("rel_btns", bus.btns, 4'b0000);
    check("rel_stable", {3'b0, bus.stable}, 4'b0001);

    // 2. Clean press on DOWN
    bus.btns_raw[BTN_DOWN] = 1'b1;
    step(1);
    check("press_e0_stable", {3'b0, bus.stable}, 4'b0001);
    step(1);
    check("press_e1_stable", {3'b0, bus.stable}, 4'b0000);
    step(7);
    check("press_e8_btns", bus.btns, 4'b0000);
    check("press_e8_stable", {3'b0, bus.stable}, 4'b0000);
    step(1);
    check("press_e9_btns", bus.btns, 4'b0100);
    check("press_e9_rise", bus.btns_rise, 4'b0100);
    check("press_e9_stable", {3'b0, bus.stable}, 4'b0001);
    step(1);
    check("press_e10_rise", bus.btns_rise, 4'b0000);
    check("press_e10_btns", bus.btns, 4'b0100);

    // 3. Bounce on UP: toggles every 3 cycles, then holds high
    for (int i = 0; i < 10; i++) begin
      bus.btns_raw[BTN_UP] = (i % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        step(1);
        check("bounce_btns", bus.btns, 4'b0100);
        check("bounce_rise", bus.btns_rise, 4'b0000);
      end
    end
    bus.btns_raw[BTN_UP] = 1'b1;
    step(9);
    check("bounce_e8_btns", bus.btns, 4'b0100);
    step(1);
    check("bounce_e9_btns", bus.btns, 4'b0101);
    check("bounce_e9_rise", bus.btns_rise, 4'b0001);
    step(1);
    check("bounce_e10_rise", bus.btns_rise, 4'b0000);

    // 4a. 7-cycle glitch on RIGHT is filtered
    bus.btns_raw[BTN_RIGHT] = 1'b1;
    step(7);
    bus.btns_raw[BTN_RIGHT] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      check("glitch7_btns", bus.btns, 4'b0101);
      check("glitch7_rise", bus.btns_rise, 4'b0000);
    end

    // 4b. 8-cycle pulse on RIGHT passes for exactly 8 cycles
    bus.btns_raw[BTN_RIGHT] = 1'b1;
    step(8);
    bus.btns_raw[BTN_RIGHT] = 1'b0;
    step(1);
    check("pulse8_e8_btns", bus.btns, 4'b0101);
    step(1);
    check("pulse8_e9_btns", bus.btns, 4'b0111);
    check("pulse8_e9_rise", bus.btns_rise, 4'b0010);
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("pulse8_hold_btns", bus.btns, 4'b0111);
      check("pulse8_hold_rise", bus.btns_rise, 4'b0000);
    end
    step(1);
    check("pulse8_e17_btns", bus.btns, 4'b0101);

    // 5. Simultaneous press of UP and LEFT from all released
    bus.btns_raw = 4'b0000;
    step(10);
    check("sim_clear_btns", bus.btns, 4'b0000);
    bus.btns_raw = 4'b1001;
    step(9);
    check("sim_e8_btns", bus.btns, 4'b0000);
    step(1);
    check("sim_e9_btns", bus.btns, 4'b1001);
    check("sim_e9_rise", bus.btns_rise, 4'b1001);
    step(1);
    check("sim_e10_rise", bus.btns_rise, 4'b0000);
    bus.btns_raw = 4'b0001;
    step(9);
    check("left_rel_e8_btns", bus.btns, 4'b1001);
    step(1);
    check("left_rel_e9_btns", bus.btns, 4'b0001);
    check("left_rel_e9_rise", bus.btns_rise, 4'b0000);
    step(1);
    check("left_rel_e10_rise", bus.btns_rise, 4'b0000);

    // 6. Async reset while DOWN is mid-count
    bus.btns_raw = 4'b0101;
    step(7);
    check("arst_pre_btns", bus.btns, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("arst_btns", bus.btns, 4'b0000);
    check("arst_rise", bus.btns_rise, 4'b0000);
    check("arst_stable", {3'b0, bus.stable}, 4'b0001);
    step(2);
    rst = 1'b0;
    step(9);
    check("arst_e8_btns", bus.btns, 4'b0000);
    step(1);
    check("arst_e9_btns", bus.btns, 4'b0101);
    check("arst_e9_rise", bus.btns_rise, 4'b0101);
    step(1);
    check("arst_e10_rise", bus.btns_rise, 4'b0000);
    check("arst_e10_stable", {3'b0, bus.stable}, 4'b0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
